// File: rtl/serial_uart_bridge.sv
// Serial-port peripheral for the processor. Bridges its byte read/write streams
// to an 8N1 UART line pair, with a show-ahead FIFO in each direction.

module serial_uart_bridge_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [7:0]                 push_data_i,
   input  logic                       pop_i,
   output logic [7:0]                 head_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   // A push into a full FIFO is refused even if a pop frees a slot this cycle.
   assign do_push = push_i && (count_q != CNT_FULL);
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q] <= push_data_i;
   end

   assign head_o  = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
   assign count_o = count_q;
endmodule

module serial_uart_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] proc_rx_data,
   output logic       proc_rx_valid,
   input  logic       proc_rd_en,
   input  logic [7:0] proc_wr_data,
   input  logic       proc_wr_en,
   output logic       proc_tx_ready,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       rx_overrun,
   output logic       tx_overflow,
   output logic       frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [FW:0]   CNT_FULL = (FW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [FW:0]   tx_count, rx_count;
   logic [7:0]    tx_head;
   logic          tx_full, rx_full, tx_pop, rx_push, frame_err_set;

   logic [1:0]    tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic          txd_q, txd_d;
   logic          sync1_q, sync2_q;
   logic          rx_overrun_q, tx_overflow_q, frame_err_q;

   serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (proc_wr_en),
      .push_data_i (proc_wr_data),
      .pop_i       (tx_pop),
      .head_o      (tx_head),
      .count_o     (tx_count)
   );

   serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (rx_push),
      .push_data_i (rx_shift_q),
      .pop_i       (proc_rd_en),
      .head_o      (proc_rx_data),
      .count_o     (rx_count)
   );

   assign tx_full = (tx_count == CNT_FULL);
   assign rx_full = (rx_count == CNT_FULL);

   // Transmitter: the STOP state reloads directly so queued frames run back to back.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (tx_count != '0) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               txd_d      = 1'b0;
               tx_cnt_d   = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_END) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               txd_d      = tx_shift_q[0];
               tx_state_d = S_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_END) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  txd_d      = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  txd_d      = tx_shift_q[1];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
         default: begin
            if (tx_cnt_q == BIT_END) begin
               tx_cnt_d = '0;
               if (tx_count != '0) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  txd_d      = 1'b0;
                  tx_state_d = S_START;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
      endcase
   end

   // Receiver: samples mid-bit, and returns to IDLE right after the stop sample.
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_push       = 1'b0;
      frame_err_set = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!sync2_q) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_END) begin
               rx_cnt_d   = '0;
               rx_state_d = sync2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_END) begin
               rx_cnt_d   = '0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
         default: begin
            if (rx_cnt_q == BIT_END) begin
               rx_cnt_d      = '0;
               rx_state_d    = S_IDLE;
               rx_push       = sync2_q;
               frame_err_set = !sync2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q    <= S_IDLE;
         tx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         txd_q         <= 1'b1;
         rx_state_q    <= S_IDLE;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         rx_overrun_q  <= 1'b0;
         tx_overflow_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         txd_q         <= txd_d;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         sync1_q       <= uart_rxd;
         sync2_q       <= sync1_q;
         rx_overrun_q  <= rx_overrun_q | (rx_push & rx_full);
         tx_overflow_q <= tx_overflow_q | (proc_wr_en & tx_full);
         frame_err_q   <= frame_err_q | frame_err_set;
      end
   end

   always_ff @(posedge clock) begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
   end

   assign proc_rx_valid = (rx_count != '0);
   assign proc_tx_ready = !tx_full;
   assign uart_txd      = txd_q;
   assign rx_overrun    = rx_overrun_q;
   assign tx_overflow   = tx_overflow_q;
   assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Bench for serial_uart_bridge: directed frame sequences, a cycle table for the
// TX FIFO flags, and randomized traffic against queue-based expectations.

module tb_serial_uart_bridge;
   localparam int C = 4;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] proc_rx_data;
   logic       proc_rx_valid;
   logic       proc_rd_en = 1'b0;
   logic [7:0] proc_wr_data = 8'h00;
   logic       proc_wr_en = 1'b0;
   logic       proc_tx_ready;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;
   logic       rx_overrun, tx_overflow, frame_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rst_cnt = 0;

   logic [7:0] tx_seen[$];
   int         tx_start[$];
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       exp_ready;
      logic       exp_ovf;
   } vec_t;
   vec_t tbl[7];

   serial_uart_bridge #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .proc_rx_data  (proc_rx_data),
      .proc_rx_valid (proc_rx_valid),
      .proc_rd_en    (proc_rd_en),
      .proc_wr_data  (proc_wr_data),
      .proc_wr_en    (proc_wr_en),
      .proc_tx_ready (proc_tx_ready),
      .uart_rxd      (uart_rxd),
      .uart_txd      (uart_txd),
      .rx_overrun    (rx_overrun),
      .tx_overflow   (tx_overflow),
      .frame_err     (frame_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset) rst_cnt <= rst_cnt + 1;
   end

   function automatic void chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endfunction

   function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endfunction

   function automatic void chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   // Line decoder for uart_txd: records each complete frame and its start cycle.
   initial begin : tx_monitor
      forever begin
         @(negedge clock);
         if (!reset && uart_txd === 1'b0) begin : frame
            int rc, st;
            logic [7:0] b;
            logic stop_ok;
            rc = rst_cnt;
            st = cyc;
            repeat (C / 2) @(negedge clock);
            for (int k = 0; k < 8; k++) begin
               repeat (C) @(negedge clock);
               b[k] = uart_txd;
            end
            repeat (C) @(negedge clock);
            stop_ok = uart_txd;
            if (rst_cnt == rc) begin
               chk1("tx_stop_bit", stop_ok, 1'b1);
               tx_seen.push_back(b);
               tx_start.push_back(st);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(posedge clock);
      #1;
      for (int k = 0; k < 10; k++) begin
         uart_rxd = f[k];
         repeat (C) @(posedge clock);
         #1;
      end
      uart_rxd = 1'b1;
   endtask

   task automatic wait_rx(input string name);
      int n;
      n = 0;
      while (!proc_rx_valid && n < 12) begin
         @(negedge clock);
         n++;
      end
      chk1(name, proc_rx_valid, 1'b1);
   endtask

   task automatic pop_rx();
      @(negedge clock);
      proc_rd_en = 1'b1;
      @(negedge clock);
      proc_rd_en = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clock);
      proc_wr_data = b;
      proc_wr_en   = 1'b1;
      @(negedge clock);
      proc_wr_en   = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      logic [9:0] f;
      int base, lows, tries, pushed, got, nseen;

      tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'h11, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h12, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'h13, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 8'h14, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'h15, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clock);
      chk1("rst_txd", uart_txd, 1'b1);
      chk1("rst_tx_ready", proc_tx_ready, 1'b1);
      chk1("rst_rx_valid", proc_rx_valid, 1'b0);
      chk8("rst_rx_data", proc_rx_data, 8'h00);
      chk1("rst_flags", rx_overrun | tx_overflow | frame_err, 1'b0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Single TX frame, checked sample by sample
      push_byte(8'hA5);
      chk1("a5_idle_before", uart_txd, 1'b1);
      f = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10 * C; k++) begin
         @(negedge clock);
         chk1($sformatf("a5_bit%0d_s%0d", k / C, k % C), uart_txd, f[k / C]);
      end
      for (int k = 0; k < C; k++) begin
         @(negedge clock);
         chk1("a5_idle_after", uart_txd, 1'b1);
      end
      chk1("a5_no_overflow", tx_overflow, 1'b0);

      // Single RX frame, then pop
      send_frame(8'h3C, 1'b1);
      wait_rx("rx3c_valid");
      chk8("rx3c_data", proc_rx_data, 8'h3C);
      pop_rx();
      chk1("rx3c_popped_valid", proc_rx_valid, 1'b0);
      chk8("rx3c_popped_data", proc_rx_data, 8'h00);

      // RX overrun: five frames into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      repeat (8) @(negedge clock);
      chk1("ovr_flag", rx_overrun, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         chk1($sformatf("ovr_valid%0d", i), proc_rx_valid, 1'b1);
         chk8($sformatf("ovr_data%0d", i), proc_rx_data, 8'(i));
         pop_rx();
      end
      chk1("ovr_empty_valid", proc_rx_valid, 1'b0);
      chk8("ovr_empty_data", proc_rx_data, 8'h00);

      // False start, bad stop bit, then a good frame
      @(posedge clock);
      #1;
      uart_rxd = 1'b0;
      @(posedge clock);
      #1;
      uart_rxd = 1'b1;
      repeat (20) @(negedge clock);
      chk1("glitch_valid", proc_rx_valid, 1'b0);
      chk1("glitch_frame_err", frame_err, 1'b0);
      chk1("glitch_overrun_kept", rx_overrun, 1'b1);
      send_frame(8'h55, 1'b0);
      repeat (10) @(negedge clock);
      chk1("ferr_flag", frame_err, 1'b1);
      chk1("ferr_valid", proc_rx_valid, 1'b0);
      send_frame(8'h66, 1'b1);
      wait_rx("rx66_valid");
      chk8("rx66_data", proc_rx_data, 8'h66);
      pop_rx();
      chk1("rx66_popped", proc_rx_valid, 1'b0);

      // TX FIFO fill table: six consecutive pushes, last one dropped
      base = tx_seen.size();
      @(negedge clock);
      for (int i = 0; i < 7; i++) begin
         proc_wr_en   = tbl[i].wr_en;
         proc_wr_data = tbl[i].wr_data;
         @(negedge clock);
         chk1($sformatf("tbl%0d_ready", i), proc_tx_ready, tbl[i].exp_ready);
         chk1($sformatf("tbl%0d_ovf", i), tx_overflow, tbl[i].exp_ovf);
      end
      proc_wr_en = 1'b0;
      for (int n = 0; n < 400 && tx_seen.size() < base + 5; n++) @(negedge clock);
      repeat (60) @(negedge clock);
      chki("fill_frame_count", tx_seen.size(), base + 5);
      if (tx_seen.size() >= base + 5) begin
         for (int i = 0; i < 5; i++)
            chk8($sformatf("fill_byte%0d", i), tx_seen[base + i], 8'(8'h10 + i));
         for (int i = 1; i < 5; i++)
            chki($sformatf("fill_gap%0d", i), tx_start[base + i] - tx_start[base + i - 1], 10 * C);
      end

      // Reset in the middle of a TX frame with bytes queued and every flag set
      send_frame(8'h77, 1'b1);
      wait_rx("pre_rst_rx_valid");
      nseen = tx_seen.size();
      push_byte(8'h20);
      push_byte(8'h21);
      push_byte(8'h22);
      repeat (14) @(negedge clock);
      chk1("pre_rst_flags", rx_overrun & tx_overflow & frame_err, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      chk1("midrst_txd", uart_txd, 1'b1);
      chk1("midrst_tx_ready", proc_tx_ready, 1'b1);
      chk1("midrst_rx_valid", proc_rx_valid, 1'b0);
      chk8("midrst_rx_data", proc_rx_data, 8'h00);
      chk1("midrst_overrun", rx_overrun, 1'b0);
      chk1("midrst_overflow", tx_overflow, 1'b0);
      chk1("midrst_frame_err", frame_err, 1'b0);
      reset = 1'b0;
      lows = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (uart_txd !== 1'b1) lows++;
      end
      chki("post_rst_txd_low_cycles", lows, 0);
      chki("post_rst_frames", tx_seen.size(), nseen);

      // Randomized traffic in both directions
      base = tx_seen.size();
      fork
         begin : rand_tx
            logic [7:0] b;
            pushed = 0;
            tries = 0;
            while (pushed < 12 && tries < 2000) begin
               repeat ($urandom_range(0, 30)) @(negedge clock);
               @(negedge clock);
               tries++;
               if (proc_tx_ready) begin
                  b = 8'($urandom);
                  proc_wr_data = b;
                  proc_wr_en   = 1'b1;
                  exp_tx.push_back(b);
                  pushed++;
                  @(negedge clock);
                  proc_wr_en = 1'b0;
               end
            end
         end
         begin : rand_rx_drive
            logic [7:0] b;
            for (int i = 0; i < 10; i++) begin
               b = 8'($urandom);
               exp_rx.push_back(b);
               send_frame(b, 1'b1);
               repeat ($urandom_range(0, 10)) @(posedge clock);
            end
         end
         begin : rand_rx_read
            got = 0;
            for (int c = 0; c < 4000 && got < 10; c++) begin
               @(negedge clock);
               if (proc_rx_valid && ($urandom_range(0, 1) == 1)) begin
                  if (exp_rx.size() == 0) begin
                     chki("rand_rx_unexpected_byte", 1, 0);
                  end else begin
                     chk8($sformatf("rand_rx%0d", got), proc_rx_data, exp_rx.pop_front());
                  end
                  proc_rd_en = 1'b1;
                  got++;
               end else begin
                  proc_rd_en = 1'b0;
               end
            end
            @(negedge clock);
            proc_rd_en = 1'b0;
            chki("rand_rx_count", got, 10);
         end
      join
      for (int n = 0; n < 3000 && tx_seen.size() < base + exp_tx.size(); n++) @(negedge clock);
      chki("rand_tx_count", tx_seen.size() - base, exp_tx.size());
      for (int i = 0; i < exp_tx.size() && base + i < tx_seen.size(); i++)
         chk8($sformatf("rand_tx%0d", i), tx_seen[base + i], exp_tx[i]);
      chk1("rand_no_flags", rx_overrun | tx_overflow | frame_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Peripheral at the far end of the processor's serial IO port: serves the byte stream the processor reads (serial_in / serial_valid_in / serial_rden_out) and accepts the bytes it writes (serial_out / serial_wren_out / serial_ready_in).
- Converts both streams to an external 8N1 UART line pair (rxd/txd), buffering each direction in a FIFO.
- Sits at top level beside the processor; its proc_* ports connect to the serial ports that data_memory exposes.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; integer >= 4.
- FIFO_DEPTH, 8: entries per FIFO; power of 2, >= 2.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- proc_rx_data  output  8  head byte of RX FIFO; drives the processor's serial_in.
- proc_rx_valid  output  1  RX FIFO non-empty; drives serial_valid_in.
- proc_rd_en  input  1  pop RX FIFO head; from serial_rden_out.
- proc_wr_data  input  8  byte to transmit; from serial_out.
- proc_wr_en  input  1  push proc_wr_data into TX FIFO; from serial_wren_out.
- proc_tx_ready  output  1  TX FIFO not full; drives serial_ready_in.
- uart_rxd  input  1  asynchronous serial line in, idle high.
- uart_txd  output  1  serial line out, idle high.
- rx_overrun  output  1  sticky: received byte dropped because RX FIFO full.
- tx_overflow  output  1  sticky: proc write dropped because TX FIFO full.
- frame_err  output  1  sticky: received stop bit sampled low.

Behaviour:
- Reset: both FIFOs emptied; proc_rx_valid=0, proc_rx_data=8'h00, proc_tx_ready=1, uart_txd=1, all sticky flags=0, both FSMs to IDLE, synchronizer flops=1. Reset mid-frame aborts the frame; uart_txd is 1 from the first edge with reset high.
- FIFOs: show-ahead. proc_rx_data is valid while proc_rx_valid=1 and is forced to 8'h00 when the FIFO is empty.
- Push accepted only if occupancy < FIFO_DEPTH at the start of the cycle. A push to a full FIFO is dropped even when a pop occurs in the same cycle.
- Pop on an empty FIFO is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and occupancy is unchanged.
- Flags are registered from occupancy: proc_rx_valid = (rx count != 0), proc_tx_ready = (tx count != FIFO_DEPTH).
- proc_wr_en while TX FIFO full: byte dropped, tx_overflow set on the next edge.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if TX FIFO non-empty, pop the byte into the shift register, go to START, uart_txd=0.
  - START: hold uart_txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles, then IDLE, or directly START if the FIFO is non-empty. Back-to-back frames therefore have no idle gap.
  - Latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE drives uart_txd low from edge N+1. Each frame lasts exactly 10*CLKS_PER_BIT cycles.
  - uart_txd comes directly from a flop.
- RX path: uart_rxd passes through a 2-flop synchronizer; all RX decisions use the synchronized value.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a low sample goes to START and clears the bit counter.
  - START: re-sample at CLKS_PER_BIT/2 cycles after the falling edge. If high, it is a false start: go to IDLE, nothing is recorded.
  - DATA: sample 8 bits at mid-bit (every CLKS_PER_BIT cycles), shifting LSB first.
  - STOP: sample at mid-bit.
    - If 1: push the byte into the RX FIFO; if the FIFO is full, drop it and set rx_overrun.
    - If 0: discard the byte and set frame_err.
    - Either way go to IDLE immediately after the stop sample, so a following start bit half a bit later is caught.
  - The byte becomes visible on proc_rx_valid one cycle after the stop-bit sample edge.
- Sticky flags clear only on reset.
- Counters: baud counter width clog2(CLKS_PER_BIT); FIFO pointers log2(FIFO_DEPTH) bits wrapping modulo depth; occupancy counters one bit wider.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=4. Push 0xA5 at idle -> uart_txd goes 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles, then idle high; tx_overflow stays 0.
- Drive a uart_rxd frame for 0x3C -> proc_rx_valid=1 with proc_rx_data=0x3C one cycle after the stop sample. One-cycle proc_rd_en -> proc_rx_valid=0 and proc_rx_data=0x00 next cycle.
- Push 0x10..0x15 on six consecutive cycles -> 0x10 moves to the shifter and 0x11..0x14 fill the FIFO. proc_tx_ready=0, 0x15 is dropped, tx_overflow=1. uart_txd emits exactly five back-to-back frames 0x10..0x14 with no idle gap.
- Receive five frames 0x01..0x05 with no reads -> rx_overrun=1. Four reads return 0x01..0x04 in order, then proc_rx_valid=0.
- uart_rxd low for 1 cycle -> no byte, flags unchanged. Then a frame 0x55 with stop bit 0 -> frame_err=1, proc_rx_valid stays 0. Then a valid frame 0x66 -> received normally.
- Assert reset for 1 cycle mid-DATA of a TX frame with bytes queued and flags set -> uart_txd=1, proc_tx_ready=1, proc_rx_valid=0, all flags 0. No further frames are transmitted.
